// File: rtl/ui_layer_compositor.sv
// ui_layer_compositor: two-stage pixel compositor feeding the VGA pins.
// Stage 1 registers the renderer layers, the syncs and the turn-highlight hit.
// Stage 2 applies fixed layer priority and drives the outputs.
// A blink timer toggles the highlight every BLINK_FRAMES frames.
// Optional feature (macro UI_DIM_EN): camera pixels inside the status rows
// are dimmed to half intensity per channel.
module ui_layer_compositor #(
  parameter int          PIPE_LAT     = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter int          HL_T         = 2,
  parameter int          HL_Y0        = 24,
  parameter int          HL_Y1        = 55,
  parameter int          HL_P1_X0     = 32,
  parameter int          HL_P1_X1     = 247,
  parameter int          HL_P2_X0     = 352,
  parameter int          HL_P2_X1     = 567,
  parameter logic [11:0] HL_COLOR     = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] status_color,
  input  logic        status_en,
  input  logic [11:0] sprite_color,
  input  logic        sprite_en,
  input  logic [11:0] board_color,
  input  logic        board_en,
  input  logic [11:0] cam_color,
  input  logic        turn_valid,
  input  logic        active_player,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  localparam logic [9:0] P1_X0 = 10'(HL_P1_X0);
  localparam logic [9:0] P1_X1 = 10'(HL_P1_X1);
  localparam logic [9:0] P1_XL = 10'(HL_P1_X0 + HL_T);
  localparam logic [9:0] P1_XR = 10'(HL_P1_X1 - HL_T);
  localparam logic [9:0] P2_X0 = 10'(HL_P2_X0);
  localparam logic [9:0] P2_X1 = 10'(HL_P2_X1);
  localparam logic [9:0] P2_XL = 10'(HL_P2_X0 + HL_T);
  localparam logic [9:0] P2_XR = 10'(HL_P2_X1 - HL_T);
  localparam logic [9:0] Y0    = 10'(HL_Y0);
  localparam logic [9:0] Y1    = 10'(HL_Y1);
  localparam logic [9:0] Y_T   = 10'(HL_Y0 + HL_T);
  localparam logic [9:0] Y_B   = 10'(HL_Y1 - HL_T);
  localparam logic [7:0] CNT_LAST = 8'(BLINK_FRAMES - 1);

  logic [9:0]  bx0, bx1, bxl, bxr;
  logic        hl_hit;
  logic        in_rows;

  logic [11:0] s1_status_color, s1_sprite_color, s1_board_color, s1_cam_color;
  logic        s1_status_en, s1_sprite_en, s1_board_en;
  logic        s1_de, s1_hsync, s1_vsync, s1_hl_hit;
`ifdef UI_DIM_EN
  logic        s1_in_rows;
`endif

  logic        vsync_prev;
  logic        vsync_fall;
  logic [7:0]  frame_cnt;
  logic        blink_phase;
  logic        last_player;
  logic [11:0] pix_next;

  // Only the active player's box is considered; the two boxes never overlap.
  always_comb begin
    bx0 = active_player ? P2_X0 : P1_X0;
    bx1 = active_player ? P2_X1 : P1_X1;
    bxl = active_player ? P2_XL : P1_XL;
    bxr = active_player ? P2_XR : P1_XR;
    in_rows = (pixel_y >= Y0) && (pixel_y <= Y1);
    hl_hit = (pixel_x >= bx0) && (pixel_x <= bx1) && in_rows &&
             ((pixel_x < bxl) || (pixel_x > bxr) || (pixel_y < Y_T) || (pixel_y > Y_B));
  end

  // Stage 1: capture layers, timing and the gated highlight hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_status_color <= '0;
      s1_sprite_color <= '0;
      s1_board_color  <= '0;
      s1_cam_color    <= '0;
      s1_status_en    <= 1'b0;
      s1_sprite_en    <= 1'b0;
      s1_board_en     <= 1'b0;
      s1_de           <= 1'b0;
      s1_hsync        <= 1'b1;
      s1_vsync        <= 1'b1;
      s1_hl_hit       <= 1'b0;
`ifdef UI_DIM_EN
      s1_in_rows      <= 1'b0;
`endif
    end else begin
      s1_status_color <= status_color;
      s1_sprite_color <= sprite_color;
      s1_board_color  <= board_color;
      s1_cam_color    <= cam_color;
      s1_status_en    <= status_en;
      s1_sprite_en    <= sprite_en;
      s1_board_en     <= board_en;
      s1_de           <= de_in;
      s1_hsync        <= hsync_in;
      s1_vsync        <= vsync_in;
      s1_hl_hit       <= hl_hit & turn_valid;
`ifdef UI_DIM_EN
      s1_in_rows      <= in_rows;
`endif
    end
  end

  // Fixed-priority layer select for stage 2.
  always_comb begin
    pix_next = 12'h000;
    if (!s1_de) begin
      pix_next = 12'h000;
    end else if (s1_status_en) begin
      pix_next = s1_status_color;
    end else if (s1_sprite_en) begin
      pix_next = s1_sprite_color;
    end else if (s1_hl_hit && blink_phase) begin
      pix_next = HL_COLOR;
    end else if (s1_board_en) begin
      pix_next = s1_board_color;
    end else begin
`ifdef UI_DIM_EN
      if (s1_in_rows) begin
        pix_next = {1'b0, s1_cam_color[11:9], 1'b0, s1_cam_color[7:5], 1'b0, s1_cam_color[3:1]};
      end else begin
        pix_next = s1_cam_color;
      end
`else
      pix_next = s1_cam_color;
`endif
    end
  end

  // Stage 2: registered outputs, syncs taken from stage 1 for a 2-clock match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      de_out    <= 1'b0;
    end else begin
      rgb_out   <= pix_next;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      de_out    <= s1_de;
    end
  end

  assign vsync_fall = vsync_prev & ~vsync_in;

  // Blink timer: turn start or player change restarts a visible half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev  <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      last_player <= 1'b0;
    end else begin
      vsync_prev  <= vsync_in;
      last_player <= active_player;
      if (!turn_valid || (active_player != last_player)) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (vsync_fall) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule
